fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction-fetch stage that sits directly upstream of the 2048×32 instruction memory and feeds the decode stage. It holds the 64-bit program counter and drives the memory's word address. It captures the combinationally read instruction into the IF/ID pipeline register under a valid/ready handshake. It also handles redirects (branch/jump/flush) and address faults.

## Interface
Parameters:
- `width`, 32, instruction width in bits.
- `depth`, 2048, instruction memory words.
- `adr_in`, 11, memory word-address width (2^adr_in = depth).
- `RESET_PC`, 64'h0, PC value loaded at reset.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `redirect_valid`  in  1  load `redirect_pc` this edge and flush IF/ID.
- `redirect_pc`  in  64  target byte address.
- `id_ready`  in  1  decode accepts the IF/ID entry this edge.
- `imem_adr`  out  adr_in  word address to instruction memory, = `pc[adr_in+1:2]` (combinational).
- `imem_instr`  in  width  instruction returned combinationally for `imem_adr`.
- `id_valid`  out  1  IF/ID entry valid.
- `id_instr`  out  width  registered instruction.
- `id_pc`  out  64  byte address of `id_instr`.
- `id_pc_plus4`  out  64  `id_pc + 4`, mod 2^64.
- `fault`  out  1  fetch halted on a bad PC.
- `fault_pc`  out  64  offending PC, valid while `fault`=1.

## Operation
- States: BOOT, RUN, FAULT. Reset enters BOOT.
- BOOT:
  - Lasts exactly one cycle; no capture is made.
  - Next state is RUN.
  - `redirect_valid` in BOOT loads the PC and goes to RUN.
- PC checks, both combinational on the current `pc`:
  - `bad_align` = `pc[1:0] != 0`.
  - `bad_range` = `pc[63:adr_in+2] != 0`.
- Definitions:
  - `slot_free` = `!id_valid || id_ready`.
  - `advance` = state RUN && `slot_free` && !`bad_align` && !`bad_range` && !`redirect_valid`.
- On `advance`:
  - `id_instr <= imem_instr`, `id_pc <= pc`, `id_pc_plus4 <= pc+4`, `id_valid <= 1`.
  - `pc <= pc+4`.
- Consumption without refill: RUN && `id_ready` && `id_valid` && !`advance` → `id_valid <= 0`.
- Stall: `id_valid` && !`id_ready` → PC and IF/ID are held bit-exact.
- Fault entry: in RUN, `slot_free` && (`bad_align` || `bad_range`) && !`redirect_valid`.
  - State goes to FAULT; `fault <= 1`; `fault_pc <= pc`.
  - PC is held and no capture is made.
- In FAULT:
  - No fetch occurs.
  - A pending IF/ID entry drains normally when `id_ready`=1.
- Redirect priority: `redirect_valid` beats stall, fault and advance, in any non-reset state.
  - `pc <= redirect_pc`; `id_valid <= 0`.
  - `fault <= 0`; state goes to RUN.
- Redirect target checks: a misaligned or out-of-range `redirect_pc` is accepted as-is. The fault is raised by the checks on the following cycle.
- PC arithmetic: 64-bit, wraps modulo 2^64. Running past byte address `depth*4 - 4` causes `bad_range` on the next fetch, which faults.

## Timing
- Reset values, applied immediately on `rst` assertion regardless of `clk`:
  - `pc`=`RESET_PC`, state=BOOT.
  - `id_valid`=0, `id_instr`=0, `id_pc`=0, `id_pc_plus4`=0.
  - `fault`=0, `fault_pc`=0.
- `imem_adr` follows `pc` combinationally. Memory read is zero-latency.
- Fetch-to-decode latency is 1 cycle: the instruction at `pc` appears on `id_instr` after the advancing edge.
- Throughput is 1 instruction/cycle when `id_ready`=1.
- First valid entry timing: first edge after reset release is BOOT→RUN; second edge captures `RESET_PC`.
- Redirect timing:
  - Redirect at edge N gives `id_valid`=0 after N.
  - Target instruction appears after N+1, so the redirect bubble is exactly 1 cycle.
- Reset asserted mid-operation: all state returns to reset values asynchronously. An in-flight IF/ID entry is discarded.

## Test plan
- Memory words 0..3 = 0xA0,0xA1,0xA2,0xA3; `RESET_PC`=0; `id_ready`=1 → after BOOT, `id_instr` is 0xA0..0xA3 on consecutive cycles with `id_pc` 0,4,8,12 and `id_pc_plus4` 4,8,12,16.
- `id_ready`=0 for 3 cycles while `id_instr`=0xA1 → `id_instr`, `id_pc`=4 and `imem_adr`=2 all hold. On release the next entry is 0xA2.
- `redirect_valid`=1, `redirect_pc`=0x40, during a stall → `id_valid`=0 after that edge. Next entry has `id_pc`=0x40 and `id_instr`=mem[16].
- Redirect to 0x1FFC (last word) with `id_ready`=1 → mem[2047] is delivered, then `fault`=1 with `fault_pc`=0x2000. `id_valid` drops after consumption. A redirect to 0 clears `fault` and resumes fetch.
- Redirect to 0x6 → `fault`=1 and `fault_pc`=0x6 one edge later. No capture is made.
- `rst` pulsed between clock edges while `id_valid`=1 → all outputs zero immediately and state returns to BOOT. The sequence restarts from `RESET_PC`.

Source files
------------

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the 64-bit PC, addresses the instruction memory and
// fills the IF/ID register under a valid/ready handshake, with redirect and fault handling.
module fetch_unit #(
  parameter int          width    = 32,
  parameter int          depth    = 2048,
  parameter int          adr_in   = 11,
  parameter logic [63:0] RESET_PC = 64'h0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_valid,
  input  logic [63:0]       redirect_pc,
  input  logic              id_ready,
  output logic [adr_in-1:0] imem_adr,
  input  logic [width-1:0]  imem_instr,
  output logic              id_valid,
  output logic [width-1:0]  id_instr,
  output logic [63:0]       id_pc,
  output logic [63:0]       id_pc_plus4,
  output logic              fault,
  output logic [63:0]       fault_pc
);

  typedef enum logic [1:0] {BOOT, RUN, FAULT} state_t;

  // First byte address past the memory; equals pc[63:adr_in+2] != 0 because depth = 2**adr_in.
  localparam logic [63:0] pc_limit = 64'(depth) * 64'd4;

  state_t      state, state_nxt;
  logic [63:0] pc;
  logic        bad_align, bad_range, slot_free, advance, fault_entry;

  assign imem_adr    = pc[adr_in+1:2];
  assign bad_align   = pc[1:0] != 2'b00;
  assign bad_range   = pc >= pc_limit;
  assign slot_free   = !id_valid || id_ready;
  assign advance     = (state == RUN) && slot_free && !bad_align && !bad_range && !redirect_valid;
  assign fault_entry = (state == RUN) && slot_free && (bad_align || bad_range) && !redirect_valid;

  always_comb begin
    // NOTE: next-state gets a default before the case so no path leaves it unassigned (no latch).
    state_nxt = state;
    case (state)
      BOOT:    state_nxt = RUN;
      RUN:     if (fault_entry) state_nxt = FAULT;
      FAULT:   state_nxt = FAULT;
      default: state_nxt = BOOT;
    endcase
    if (redirect_valid) state_nxt = RUN;
  end

  // NOTE: reset is in the sensitivity list, so it takes effect immediately, not on the next edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= BOOT;
    else     state <= state_nxt;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      id_valid    <= 1'b0;
      id_instr    <= '0;
      id_pc       <= '0;
      id_pc_plus4 <= '0;
      fault       <= 1'b0;
      fault_pc    <= '0;
    end else if (redirect_valid) begin
      pc       <= redirect_pc;
      id_valid <= 1'b0;
      fault    <= 1'b0;
    end else begin
      if (advance) begin
        id_instr    <= imem_instr;
        id_pc       <= pc;
        id_pc_plus4 <= pc + 64'd4;
        id_valid    <= 1'b1;
        pc          <= pc + 64'd4;
      end else if (id_valid && id_ready) begin
        id_valid <= 1'b0;
      end
      if (fault_entry) begin
        fault    <= 1'b1;
        fault_pc <= pc;
      end
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios then random redirects/stalls, checked against a
// transaction-level fetch model and a scoreboard of expected decode-stage entries.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [63:0] redirect_pc;
  logic        id_ready;
  logic [10:0] imem_adr;
  logic [31:0] imem_instr;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [63:0] id_pc;
  logic [63:0] id_pc_plus4;
  logic        fault;
  logic [63:0] fault_pc;

  fetch_unit #(.width(32), .depth(2048), .adr_in(11), .RESET_PC(64'h0)) dut (
    .clk(clk), .rst(rst), .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .id_ready(id_ready), .imem_adr(imem_adr), .imem_instr(imem_instr), .id_valid(id_valid),
    .id_instr(id_instr), .id_pc(id_pc), .id_pc_plus4(id_pc_plus4), .fault(fault),
    .fault_pc(fault_pc)
  );

  always #5 clk = ~clk;

  logic [31:0] mem [2048];
  assign imem_instr = mem[imem_adr];

  typedef struct {
    logic [31:0] instr;
    logic [63:0] pc;
  } exp_t;

  exp_t exp_q[$];
  int   n_cmp = 0, n_err = 0;
  int   n_push = 0, n_pop = 0, n_flush = 0;

  // Reference model: where fetch stands and what decode currently holds.
  logic [63:0] m_pc, m_fault_pc, m_ipc;
  logic [31:0] m_instr;
  logic        m_booting, m_halted, m_valid;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic pc_ok(input logic [63:0] p);
    return (p % 64'd4 == 64'd0) && (p < 64'd8192);
  endfunction

  task automatic model_reset();
    m_pc = 64'h0; m_booting = 1'b1; m_halted = 1'b0; m_valid = 1'b0;
    m_fault_pc = 64'h0; m_ipc = 64'h0; m_instr = 32'h0;
    n_flush += exp_q.size();
    exp_q.delete();
  endtask

  // Advance the model across one clock edge with the given inputs.
  task automatic model_edge(input logic r, input logic [63:0] rpc, input logic rdy);
    exp_t e;
    if (r) begin
      if (m_valid && !rdy) begin
        void'(exp_q.pop_back());
        n_flush++;
      end
      m_pc = rpc; m_valid = 1'b0; m_halted = 1'b0; m_booting = 1'b0;
    end else if (m_booting) begin
      m_booting = 1'b0;
    end else if (!m_valid || rdy) begin
      if (m_halted) begin
        m_valid = 1'b0;
      end else if (!pc_ok(m_pc)) begin
        m_halted = 1'b1; m_fault_pc = m_pc; m_valid = 1'b0;
      end else begin
        m_instr = mem[m_pc / 64'd4]; m_ipc = m_pc; m_valid = 1'b1;
        e.instr = m_instr; e.pc = m_pc;
        exp_q.push_back(e);
        n_push++;
        m_pc = m_pc + 64'd4;
      end
    end
  endtask

  task automatic check_state();
    check("id_valid", id_valid, m_valid);
    check("fault", fault, m_halted);
    check("imem_adr", 64'(imem_adr), (m_pc >> 2) & 64'd2047);
    if (m_valid) begin
      check("held_instr", id_instr, m_instr);
      check("held_pc", id_pc, m_ipc);
    end
    if (m_halted) check("fault_pc", fault_pc, m_fault_pc);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_valid"}, id_valid, 0);
    check({tag, "_instr"}, id_instr, 0);
    check({tag, "_pc"}, id_pc, 0);
    check({tag, "_pc4"}, id_pc_plus4, 0);
    check({tag, "_fault"}, fault, 0);
    check({tag, "_fault_pc"}, fault_pc, 0);
    check({tag, "_adr"}, 64'(imem_adr), 0);
  endtask

  task automatic step(input logic r, input logic [63:0] rpc, input logic rdy);
    @(negedge clk);
    check_state();
    redirect_valid = r; redirect_pc = rpc; id_ready = rdy;
    model_edge(r, rpc, rdy);
  endtask

  // Reset pulse wholly between two edges; the following edge is then the BOOT edge.
  task automatic pulse_reset(input logic r, input logic [63:0] rpc, input logic rdy);
    @(negedge clk);
    check_state();
    id_ready = 1'b0;
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    redirect_valid = r; redirect_pc = rpc; id_ready = rdy;
    model_reset();
    model_edge(r, rpc, rdy);
    #1 rst = 1'b0;
  endtask

  // Scoreboard monitor: every accepted IF/ID entry must match the oldest expected one.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (!rst && id_valid && id_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_unexpected_entry", {32'h0, id_instr}, 64'hDEAD_0000);
        end else begin
          e = exp_q.pop_front();
          n_pop++;
          check("sb_instr", id_instr, e.instr);
          check("sb_pc", id_pc, e.pc);
          check("sb_pc_plus4", id_pc_plus4, e.pc + 64'd4);
        end
      end
    end
  end

  initial begin
    logic [63:0] tgt;
    for (int i = 0; i < 2048; i++) mem[i] = $urandom;
    mem[0] = 32'hA0; mem[1] = 32'hA1; mem[2] = 32'hA2; mem[3] = 32'hA3;
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = 64'h0; id_ready = 1'b1;
    model_reset();

    repeat (2) @(negedge clk);
    check_zero("reset");
    @(negedge clk);
    rst = 1'b0;
    model_edge(1'b0, 64'h0, 1'b1);

    // Sequential fetch and stall
    step(0, 0, 1);
    step(0, 0, 1);
    check("first_instr", id_instr, 32'hA0);
    check("first_pc", id_pc, 0);
    check("first_pc4", id_pc_plus4, 4);
    step(0, 0, 0);
    check("second_instr", id_instr, 32'hA1);
    step(0, 0, 0);
    step(0, 0, 0);
    check("stall_adr", 64'(imem_adr), 2);
    check("stall_pc", id_pc, 4);
    check("stall_instr", id_instr, 32'hA1);
    step(0, 0, 1);
    step(0, 0, 1);
    check("after_stall_instr", id_instr, 32'hA2);
    check("after_stall_pc4", id_pc_plus4, 12);

    // Redirect during a stall
    step(0, 0, 0);
    step(1, 64'h40, 0);
    step(0, 0, 1);
    check("redir_bubble", id_valid, 0);
    step(0, 0, 1);
    check("redir_pc", id_pc, 64'h40);
    check("redir_instr", id_instr, mem[16]);

    // Run off the end of memory
    step(1, 64'h1FFC, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    check("last_word", id_instr, mem[2047]);
    check("last_pc", id_pc, 64'h1FFC);
    step(0, 0, 1);
    check("range_fault", fault, 1);
    check("range_fault_pc", fault_pc, 64'h2000);
    check("range_fault_valid", id_valid, 0);
    step(1, 0, 1);
    step(0, 0, 1);
    check("fault_cleared", fault, 0);
    step(0, 0, 1);
    check("resume_instr", id_instr, 32'hA0);

    // Misaligned redirect target
    step(1, 64'h6, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    check("align_fault", fault, 1);
    check("align_fault_pc", fault_pc, 64'h6);
    check("align_no_capture", id_valid, 0);

    // Asynchronous reset with an entry in flight, then redirect during BOOT
    step(1, 0, 1);
    step(0, 0, 1);
    pulse_reset(0, 0, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    check("restart_instr", id_instr, 32'hA0);
    check("restart_pc", id_pc, 0);
    pulse_reset(1, 64'h100, 1);
    step(0, 0, 1);
    step(0, 0, 1);
    check("boot_redir_pc", id_pc, 64'h100);

    // Random redirects and back-pressure
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 7) == 0) begin
        case ($urandom_range(0, 9))
          0, 1, 2, 3, 4, 5: tgt = 64'($urandom_range(0, 2047)) * 64'd4;
          6:                tgt = 64'h1FF0 + 64'($urandom_range(0, 3)) * 64'd4;
          7:                tgt = 64'($urandom_range(0, 2047)) * 64'd4 + 64'($urandom_range(1, 3));
          8:                tgt = {$urandom, $urandom} | 64'h1_0000_0000;
          default:          tgt = 64'h0;
        endcase
        step(1, tgt, $urandom_range(0, 3) != 0);
      end else begin
        step(0, 0, $urandom_range(0, 3) != 0);
      end
    end
    step(0, 0, 1);
    #2;
    check("sb_balance", 64'(n_push - n_pop - n_flush), 64'(m_valid));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
